qpmm_result_collector: RTL and testbench
========================================

Name: qpmm_result_collector

Overview:
Output-side companion of the pipelined QPMM multiplier, which has no handshake and no stall.
- Issue side: grants operand issue slots on a credit basis.
- Tracking: follows each issued product through the fixed QPMM latency and captures the raw Montgomery product when it emerges.
- Reduction: reduces each product (range [0, 2P)) to canonical [0, P) with a limb-serial conditional subtraction.
- Delivery: returns results in issue order over a valid/ready handshake.

Parameters:
- LAT_QPMM, 40: cycles from operand presentation at QPMM A/B to the matching qpmm_z; must equal (N+D+1)*LAT_PE + latency_FA + 1.
- FIFO_DEPTH, 8: result buffer entries; also the total credit pool.
- TAG_W, 4: width of the user tag carried alongside each product.
- LIMB_W, 64: width of the subtraction datapath; NL = ceil(ZW/LIMB_W) limbs, where ZW = $bits(uint_Mtilde2_t).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- issue_valid, in, 1: upstream is presenting A/B to QPMM this cycle.
- issue_ready, out, 1: a credit is available; A/B may enter QPMM.
- issue_tag, in, TAG_W: tag for the issued operation.
- qpmm_z, in, ZW: QPMM Z output.
- out_valid, out, 1: canonical result available.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, ZW: result in [0, P).
- out_tag, out, TAG_W: tag of out_data.
- credits, out, $clog2(FIFO_DEPTH)+1: free credits.
- err, out, 1: sticky range error (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (asynchronous assert): all pipeline valid bits, counters, FIFO pointers and the FSM are cleared. Outputs reset as follows:
  - issue_ready = 1, out_valid = 0, out_data = 0, out_tag = 0, credits = FIFO_DEPTH, err = 0.
  - Products still in QPMM at reset are discarded; their tracking bits are gone, so they are never captured.
- Issue:
  - An issue is accepted when issue_valid && issue_ready; issue_ready = (inflight + fifo_cnt + red_busy) < FIFO_DEPTH.
  - An accepted issue pushes {1, issue_tag} into a LAT_QPMM-stage shift register. Non-accepted cycles push {0, x}.
  - issue_valid while !issue_ready means the operands must not be considered issued; upstream holds them.
- Capture:
  - When the last shift stage is valid, qpmm_z and the tag are written into the FIFO on that edge.
  - The FIFO cannot overflow by construction; overflow is a verification assertion.
- Counters:
  - inflight increments on issue and decrements on capture; when both occur in the same cycle it is unchanged.
  - credits = FIFO_DEPTH - inflight - fifo_cnt - red_busy.
- Reducer FSM:
  - IDLE: if the FIFO is non-empty, pop the head into zreg/tagreg, clear borrow, set limb index k = 0, go to SUB. red_busy = 1 in all non-IDLE states.
  - SUB: one limb per cycle, diff[k] = zreg[k] - P[k] - borrow, with the borrow registered. After limb NL-1, go to OUT.
  - OUT: out_data = final borrow ? zreg : diff; out_valid = 1. Hold data and tag stable until out_ready. On the handshake go to IDLE; the next pop happens at the following edge.
- Latency:
  - With out_ready = 1 and an otherwise empty pipeline, out_valid rises LAT_QPMM + NL + 2 cycles after the issue edge.
  - Sustained throughput is one result per NL + 2 cycles.
- Arithmetic: the upper bits of P beyond its width are zero-extended to ZW. Inputs are unsigned.
- Ordering: results leave strictly in issue order.

Optional Feature:
- Macro: QPMM_COLLECT_RANGE_CHK_EN.
- Enabled:
  - SUB also computes zreg - 2P serially in parallel.
  - If no borrow results (Z >= 2P), err is set sticky until rst.
  - out_data is still zreg - P, truncated to ZW bits.
- Disabled: no second subtractor; err is tied to 0.

Decomposition:
- Shared package CURVE_PARAMS:
  - P and 2P as ZW-bit constants.
  - A LAT_QPMM localparam derived from N, D, LAT_PE and latency_FA.
  - uint_Mtilde2_t.
- Sub-module sync_fifo_tagged (FIFO_DEPTH x {TAG_W, ZW}, first-word fall-through off, count output) is a natural split.
- The limb subtractor stays inline.

Test Plan:
1. Single issue with tag 3, qpmm_z = 5 at exit: out_data = 5, out_tag = 3, out_valid at issue + LAT_QPMM + NL + 2.
2. qpmm_z = P gives 0; qpmm_z = P+7 gives 7; qpmm_z = 2P-1 gives P-1; qpmm_z = P-1 gives P-1. Run back-to-back with tags 0..3 and check order.
3. Hold out_ready = 0, issue every cycle: exactly 8 accepted, issue_ready = 0 from the 9th cycle, credits = 0. Release out_ready: all 8 drain in order, and credits return one per handshake.
4. Same-cycle issue and capture in steady stream: inflight is unchanged and credits are correct each cycle. Assert the FIFO never exceeds FIFO_DEPTH.
5. Assert rst with 3 in flight and 2 buffered, mid-SUB: all outputs are at reset values immediately. After deassert, no stale result appears; a new issue completes normally.
6. With QPMM_COLLECT_RANGE_CHK_EN, qpmm_z = 2P+1: err = 1 and stays set. Without the macro, err = 0 throughout.

Source files
------------

// File: rtl/qpmm_result_collector_pkg.sv
// Shared curve and timing constants for the QPMM result collector.
// Contents:
//   - uint_Mtilde2_t : raw Montgomery product type, range [0, 2P)
//   - ModP, ModP2    : modulus P and 2P, zero-extended to the product width
//   - QpmmLatency    : QPMM operand-to-product latency derived from the array geometry
package qpmm_result_collector_pkg;

  // QPMM array geometry.
  localparam int unsigned QpmmN     = 16;
  localparam int unsigned QpmmD     = 2;
  localparam int unsigned LatPe     = 2;
  localparam int unsigned LatencyFa = 1;

  localparam int unsigned QpmmLatency = (QpmmN + QpmmD + 1) * LatPe + LatencyFa + 1;

  localparam int unsigned Zw = 130;
  typedef logic [Zw-1:0] uint_Mtilde2_t;

  localparam uint_Mtilde2_t ModP  = 130'h1_2345_6789_ABCD_EF01_FEDC_BA98_7654_3211;
  localparam uint_Mtilde2_t ModP2 = ModP << 1;

  function automatic int unsigned num_limbs(input int unsigned limb_w);
    return (Zw + limb_w - 1) / limb_w;
  endfunction

endpackage

// File: rtl/qpmm_result_collector_fifo.sv
// Tagged result buffer between the QPMM capture point and the reducer.
// Read data is registered: a pop loads the head into rd_data_o, where it stays until the
// next pop, so the consumer can use rd_data_o as its working register.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   wr_en_i, wr_data_i  : push one entry
//   rd_en_i, rd_data_o  : pop head into the registered output
//   count_o, empty_o    : occupancy
module qpmm_result_collector_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 134
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [Width-1:0]           rd_data_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (wr_en_i && !rd_en_i)      count_q <= count_q + 1'b1;
      else if (!wr_en_i && rd_en_i) count_q <= count_q - 1'b1;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

`ifndef SYNTHESIS
  // Credit accounting guarantees a free slot for every capture.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_en_i && !rd_en_i && count_q == CntW'(Depth)));
`endif

endmodule

// File: rtl/qpmm_result_collector.sv
// Output-side collector for the stall-free pipelined QPMM multiplier.
// Grants issue credits, tracks products through the fixed QPMM latency, buffers them,
// reduces [0, 2P) to [0, P) with a limb-serial conditional subtraction and returns results
// in issue order over valid/ready.
// Optional feature (macro QPMM_COLLECT_RANGE_CHK_EN): a second serial subtractor checks
// Z < 2P and raises a sticky err_o; without the macro err_o is tied to 0.
// Ports:
//   clk_i, rst_i                        : clock, asynchronous active-high reset
//   issue_valid_i, issue_ready_o        : operand issue handshake toward QPMM
//   issue_tag_i                         : user tag of the issued operation
//   qpmm_z_i                            : raw QPMM product
//   out_valid_o, out_ready_i            : result handshake
//   out_data_o, out_tag_o               : canonical result and its tag
//   credits_o                           : free credits
//   err_o                               : sticky range error
module qpmm_result_collector
  import qpmm_result_collector_pkg::*;
#(
  parameter int unsigned LatQpmm   = QpmmLatency,
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned TagW      = 4,
  parameter int unsigned LimbW     = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [TagW-1:0]              issue_tag_i,
  input  logic [Zw-1:0]                qpmm_z_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Zw-1:0]                out_data_o,
  output logic [TagW-1:0]              out_tag_o,
  output logic [$clog2(FifoDepth):0]   credits_o,
  output logic                         err_o
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;
  localparam int unsigned Nl   = num_limbs(LimbW);
  localparam int unsigned PadW = Nl * LimbW;
  localparam int unsigned KW   = (Nl > 1) ? $clog2(Nl) : 1;

  typedef enum logic [1:0] {StIdle, StSub, StOut} state_e;

  // Issue tracking.
  logic                          issue_acc, capture;
  logic [LatQpmm-1:0]            sr_vld_q;
  logic [LatQpmm-1:0][TagW-1:0]  sr_tag_q;
  logic [CntW-1:0]               inflight_q, inflight_d;
  logic [CntW:0]                 used;
  logic                          red_busy;

  // Buffer.
  logic                          pop, fifo_empty;
  logic [CntW-1:0]               fifo_cnt;
  logic [TagW+Zw-1:0]            fifo_rd;
  uint_Mtilde2_t                 zreg;
  logic [TagW-1:0]               tagreg;

  // Reducer.
  state_e                        state_q;
  logic [KW-1:0]                 k_q;
  logic                          borrow_q;
  logic [PadW-1:0]               diff_q, diff_full, z_pad, p_pad;
  logic [LimbW-1:0]              limb_diff;
  logic                          limb_borrow;
  logic                          last_limb;

  assign red_busy      = (state_q != StIdle);
  assign used          = {1'b0, inflight_q} + {1'b0, fifo_cnt} + (CntW+1)'(red_busy);
  assign issue_ready_o = (used < (CntW+1)'(FifoDepth));
  assign credits_o     = CntW'((CntW+1)'(FifoDepth) - used);
  assign issue_acc     = issue_valid_i && issue_ready_o;
  assign capture       = sr_vld_q[LatQpmm-1];

  always_comb begin
    inflight_d = inflight_q;
    if (issue_acc && !capture)      inflight_d = inflight_q + 1'b1;
    else if (!issue_acc && capture) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_vld_q   <= '0;
      sr_tag_q   <= '0;
      inflight_q <= '0;
    end else begin
      sr_vld_q   <= {sr_vld_q[LatQpmm-2:0], issue_acc};
      sr_tag_q   <= {sr_tag_q[LatQpmm-2:0], issue_tag_i};
      inflight_q <= inflight_d;
    end
  end

  qpmm_result_collector_fifo #(
    .Depth (FifoDepth),
    .Width (TagW + Zw)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (capture),
    .wr_data_i ({sr_tag_q[LatQpmm-1], qpmm_z_i}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty)
  );

  // The FIFO read register holds the popped head for the whole SUB/OUT episode.
  assign pop    = (state_q == StIdle) && !fifo_empty;
  assign zreg   = fifo_rd[Zw-1:0];
  assign tagreg = fifo_rd[TagW+Zw-1:Zw];

  assign last_limb = (k_q == KW'(Nl - 1));

  always_comb begin
    z_pad            = '0;
    z_pad[Zw-1:0]    = zreg;
    p_pad            = '0;
    p_pad[Zw-1:0]    = ModP;
    {limb_borrow, limb_diff} = {1'b0, z_pad[k_q*LimbW +: LimbW]}
                             - {1'b0, p_pad[k_q*LimbW +: LimbW]}
                             - {{LimbW{1'b0}}, borrow_q};
    diff_full                    = diff_q;
    diff_full[k_q*LimbW +: LimbW] = limb_diff;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      k_q         <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q  <= StSub;
            k_q      <= '0;
            borrow_q <= 1'b0;
          end
        end
        StSub: begin
          diff_q   <= diff_full;
          borrow_q <= limb_borrow;
          if (last_limb) begin
            state_q     <= StOut;
            out_valid_o <= 1'b1;
            // Final borrow means Z < P: Z is already canonical.
            out_data_o  <= limb_borrow ? zreg : diff_full[Zw-1:0];
            out_tag_o   <= tagreg;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StOut: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef QPMM_COLLECT_RANGE_CHK_EN
  logic [PadW-1:0]  p2_pad;
  logic [LimbW-1:0] limb_diff2;
  logic             limb_borrow2, borrow2_q, err_q;

  always_comb begin
    p2_pad         = '0;
    p2_pad[Zw-1:0] = ModP2;
    {limb_borrow2, limb_diff2} = {1'b0, z_pad[k_q*LimbW +: LimbW]}
                               - {1'b0, p2_pad[k_q*LimbW +: LimbW]}
                               - {{LimbW{1'b0}}, borrow2_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      borrow2_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (state_q == StIdle) begin
      borrow2_q <= 1'b0;
    end else if (state_q == StSub) begin
      borrow2_q <= limb_borrow2;
      // No borrow out of Z - 2P means Z >= 2P.
      if (last_limb && !limb_borrow2) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  logic unused_diff2;
  assign unused_diff2 = ^limb_diff2;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_qpmm_result_collector.sv
module tb_qpmm_result_collector;
  import qpmm_result_collector_pkg::*;

  localparam int unsigned Lat   = QpmmLatency;
  localparam int unsigned Depth = 8;
  localparam int unsigned TagW  = 4;
  localparam int unsigned LimbW = 64;
  localparam int unsigned Nl    = (Zw + LimbW - 1) / LimbW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 issue_valid = 1'b0;
  logic                 issue_ready;
  logic [TagW-1:0]      issue_tag = '0;
  logic [Zw-1:0]        qpmm_z = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [Zw-1:0]        out_data;
  logic [TagW-1:0]      out_tag;
  logic [3:0]           credits;
  logic                 err;

  qpmm_result_collector #(
    .LatQpmm   (Lat),
    .FifoDepth (Depth),
    .TagW      (TagW),
    .LimbW     (LimbW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_tag_i   (issue_tag),
    .qpmm_z_i      (qpmm_z),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_tag_o     (out_tag),
    .credits_o     (credits),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TagW-1:0] tag;
    uint_Mtilde2_t   raw;
  } item_t;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   cyc      = 0;
  int unsigned   n_acc    = 0;
  int unsigned   n_del    = 0;
  logic          err_exp  = 1'b0;
  uint_Mtilde2_t cur_z    = '0;
  uint_Mtilde2_t z_at [int unsigned];
  item_t         exp_q [$];

  task automatic check(input string name, input logic [Zw-1:0] got, input logic [Zw-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic uint_Mtilde2_t rand_z();
    logic [159:0] r;
    uint_Mtilde2_t z;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    z = r[Zw-1:0];
    if (z >= ModP2) z = z - ModP2;
    return z;
  endfunction

  function automatic uint_Mtilde2_t reduce(input uint_Mtilde2_t z);
    return (z >= ModP) ? z - ModP : z;
  endfunction

  // Behavioural QPMM: the product of an issue accepted at edge e appears during the
  // cycle that follows edge e + Lat - 1.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (z_at.exists(cyc)) begin
      qpmm_z = z_at[cyc];
      z_at.delete(cyc);
    end else begin
      qpmm_z = rand_z();
    end
  end

  // Scoreboard: samples mid-cycle what will happen at the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("credits", credits, Depth - (n_acc - n_del));
      check("issue_ready", issue_ready, (n_acc - n_del) < Depth);
`ifdef QPMM_COLLECT_RANGE_CHK_EN
      if (out_valid && exp_q.size() > 0 && exp_q[0].raw >= ModP2) err_exp = 1'b1;
`endif
      check("err", err, err_exp);
      if (issue_valid && issue_ready) begin
        n_acc++;
        z_at[cyc + Lat] = cur_z;
        exp_q.push_back('{tag: issue_tag, raw: cur_z});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stale_out", out_valid, 1'b0);
        end else begin
          check("out_data", out_data, reduce(exp_q[0].raw));
          check("out_tag", out_tag, exp_q[0].tag);
          void'(exp_q.pop_front());
          n_del++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Called at edge+1; the issue is offered for exactly one edge.
  task automatic drive_issue(input logic [TagW-1:0] tag, input uint_Mtilde2_t z);
    issue_valid = 1'b1;
    issue_tag   = tag;
    cur_z       = z;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n_del != n_acc && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", n_del, n_acc);
  endtask

  initial begin
    int lat;
    int base;
    int e0;
    uint_Mtilde2_t bnd [4];

    #2;
    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_credits", credits, Depth);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single issue: latency counted with the accepting edge as edge 1.
    drive_issue(4'd3, 130'd5);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, Lat + Nl + 2);
    check("single_data", out_data, 130'd5);
    check("single_tag", out_tag, 4'd3);
    wait_drain();

    // Reduction boundaries, back to back.
    bnd[0] = ModP;
    bnd[1] = ModP + 130'd7;
    bnd[2] = ModP2 - 130'd1;
    bnd[3] = ModP - 130'd1;
    for (int i = 0; i < 4; i++) drive_issue(TagW'(i), bnd[i]);
    wait_drain();

    // Fill all credits with the output blocked, then drain.
    out_ready = 1'b0;
    base = n_acc;
    issue_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue_tag = TagW'($urandom);
      cur_z     = rand_z();
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    check("fill_accepted", n_acc - base, 8);
    check("fill_issue_ready", issue_ready, 1'b0);
    check("fill_credits", credits, 4'd0);
    out_ready = 1'b1;
    wait_drain();

    // Random stream with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_tag   = TagW'($urandom);
      cur_z       = rand_z();
      out_ready   = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    wait_drain();

    // Reset with 3 in flight, 2 buffered and the reducer mid-SUB.
    out_ready = 1'b0;
    e0 = cyc + 1;
    for (int i = 0; i < 6; i++) drive_issue(TagW'(i + 8), rand_z());
    while (cyc < e0 + Lat + 2) @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    z_at.delete();
    n_acc   = 0;
    n_del   = 0;
    err_exp = 1'b0;
    #1;
    check("arst_issue_ready", issue_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, '0);
    check("arst_out_tag", out_tag, '0);
    check("arst_credits", credits, Depth);
    check("arst_err", err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < Lat + 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_idle", out_valid, 1'b0);
    drive_issue(4'd6, ModP + 130'd123);
    wait_drain();

`ifdef QPMM_COLLECT_RANGE_CHK_EN
    drive_issue(4'd1, ModP2 + 130'd1);
    wait_drain();
    check("range_err_set", err, 1'b1);
    drive_issue(4'd2, 130'd9);
    wait_drain();
    check("range_err_sticky", err, 1'b1);
`else
    check("err_tied_low", err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
